// File: rtl/wb_sram_slave.sv
// wb_sram_slave: pipelined Wishbone B4 slave in front of a word-addressed
// on-chip memory. Accepted requests queue in a small command FIFO and are
// answered in order, each with one ack_o or err_o pulse. A programmable
// wait-state count stretches every response to model a slower memory.
module wb_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic                    ack_o,
    output logic                    err_o,
    output logic                    stall_o
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam logic [CW-1:0] FULL  = CW'(FIFO_DEPTH);
    localparam logic [2:0]    WLOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    logic [DATA_WIDTH-1:0] r_mem   [DEPTH];
    logic                  r_f_we  [FIFO_DEPTH];
    logic [IW-1:0]         r_f_idx [FIFO_DEPTH];
    logic                  r_f_ok  [FIFO_DEPTH];
    logic [NB-1:0]         r_f_sel [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_f_dat [FIFO_DEPTH];

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_wcnt;
    logic [2:0]            w_wcnt_nxt;

    logic                  w_push;
    logic                  w_exec;
    logic                  w_range_ok;
    logic [IW-1:0]         w_idx;
    logic                  w_h_we;
    logic                  w_h_ok;
    logic [IW-1:0]         w_h_idx;
    logic [NB-1:0]         w_h_sel;
    logic [DATA_WIDTH-1:0] w_h_dat;

    // Back-pressure comes straight from the registered occupancy, so a pop in
    // the same cycle never frees a slot early.
    assign stall_o    = (r_count == FULL);
    assign w_push     = cyc_i & stb_i & ~stall_o;
    assign w_idx      = adr_i[OFF +: IW];
    assign w_range_ok = ((adr_i >> (OFF + IW)) == '0);

    assign w_h_we  = r_f_we[r_rd_ptr];
    assign w_h_ok  = r_f_ok[r_rd_ptr];
    assign w_h_idx = r_f_idx[r_rd_ptr];
    assign w_h_sel = r_f_sel[r_rd_ptr];
    assign w_h_dat = r_f_dat[r_rd_ptr];

    // Capture each accepted request into the slot under the write pointer
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_f_we[r_wr_ptr]  <= we_i;
            r_f_idx[r_wr_ptr] <= w_idx;
            r_f_ok[r_wr_ptr]  <= w_range_ok;
            r_f_sel[r_wr_ptr] <= sel_i;
            r_f_dat[r_wr_ptr] <= dat_i;
        end
    end

    // FIFO pointers and occupancy; dropping cyc_i discards everything queued
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (!cyc_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_exec) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_exec})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Engine state and wait counter registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_wcnt  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    // Engine next state: execute the head now or after the programmed wait
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_exec      = 1'b0;
        if (!cyc_i) begin
            w_state_nxt = S_IDLE;
            w_wcnt_nxt  = 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        if (WAIT_STATES == 0) begin
                            w_exec = 1'b1;
                        end else begin
                            w_wcnt_nxt  = WLOAD;
                            w_state_nxt = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wcnt == 3'd0) begin
                        w_exec      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_wcnt_nxt = r_wcnt - 3'd1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Byte-lane memory write, on the same edge that raises the ack
    always_ff @(posedge clk_i) begin
        if (w_exec && w_h_ok && w_h_we) begin
            for (int k = 0; k < NB; k++) begin
                if (w_h_sel[k]) r_mem[w_h_idx][k*8 +: 8] <= w_h_dat[k*8 +: 8];
            end
        end
    end

    // Response strobes and read data; dat_o only moves on a read ack
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= '0;
        end else if (!cyc_i) begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
        end else begin
            ack_o <= w_exec & w_h_ok;
            err_o <= w_exec & ~w_h_ok;
            if (w_exec && w_h_ok && !w_h_we) dat_o <= r_mem[w_h_idx];
        end
    end
endmodule

// File: tb/tb_wb_sram_slave.sv
// Bench for wb_sram_slave: three instances (W=0/FD=2, W=3/FD=2, W=2/FD=4)
// checked every cycle against a transaction-level model that predicts each
// response edge as max(accept+1+W, previous response+W+1).
module tb_wb_sram_slave;
    function automatic int ws_of(int g);
        case (g)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction
    function automatic int fd_of(int g);
        return (g == 2) ? 4 : 2;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cyc [3];
    logic        stb [3];
    logic        we  [3];
    logic [31:0] adr [3];
    logic [3:0]  sel [3];
    logic [31:0] dat_w [3];
    logic [31:0] dat_r [3];
    logic        ack [3];
    logic        err [3];
    logic        stall [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        wb_sram_slave #(
            .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256),
            .WAIT_STATES(ws_of(g)), .FIFO_DEPTH(fd_of(g))
        ) u_dut (
            .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc[g]), .stb_i(stb[g]),
            .we_i(we[g]), .adr_i(adr[g]), .sel_i(sel[g]), .dat_i(dat_w[g]),
            .dat_o(dat_r[g]), .ack_o(ack[g]), .err_o(err[g]), .stall_o(stall[g])
        );
    end

    typedef struct {int g; bit we; int idx; bit ok; logic [3:0] sel; logic [31:0] dat; int resp;} req_t;
    typedef struct {int g; int e; bit er; logic [31:0] d;} lg_t;

    req_t        pend[$];
    lg_t         log_q[$];
    logic [31:0] mmem [3][256];
    bit          m_ack [3];
    bit          m_err [3];
    bit          m_stall [3];
    bit          m_acc [3];
    bit          stall_seen [3];
    logic [31:0] m_dat [3];
    int          m_last [3];
    int          edge_n = 0;
    int          compared = 0;
    int          mism = 0;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mism++;
            $display("FAIL %s at edge %0d: got=%h expected=%h", name, edge_n, got, exp);
        end
    endfunction

    function automatic int count_of(int g);
        int n = 0;
        foreach (pend[i]) if (pend[i].g == g) n++;
        return n;
    endfunction

    function automatic int log_e(int i);
        return (log_q.size() > i) ? log_q[i].e : -1;
    endfunction
    function automatic logic [31:0] log_d(int i);
        return (log_q.size() > i) ? log_q[i].d : 32'hxxxxxxxx;
    endfunction
    function automatic logic [31:0] log_er(int i);
        return (log_q.size() > i) ? 32'(log_q[i].er) : 32'hxxxxxxxx;
    endfunction

    // Reference model: advances at every clock edge
    initial forever begin
        @(posedge clk);
        edge_n++;
        if (!rst_n) begin
            pend.delete();
            for (int g = 0; g < 3; g++) begin
                m_ack[g] = 0; m_err[g] = 0; m_stall[g] = 0; m_acc[g] = 0;
                m_dat[g] = '0; m_last[g] = 0;
            end
        end else begin
            for (int g = 0; g < 3; g++) begin
                m_acc[g] = 0; m_ack[g] = 0; m_err[g] = 0;
                if (!cyc[g]) begin
                    for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].g == g) pend.delete(i);
                    m_last[g] = 0;
                end else begin
                    int h;
                    h = -1;
                    for (int i = 0; i < pend.size(); i++) if (pend[i].g == g) begin h = i; break; end
                    if (h >= 0 && pend[h].resp == edge_n) begin
                        req_t r;
                        r = pend[h];
                        pend.delete(h);
                        if (!r.ok) begin
                            m_err[g] = 1;
                        end else begin
                            m_ack[g] = 1;
                            if (r.we) begin
                                for (int k = 0; k < 4; k++)
                                    if (r.sel[k]) mmem[g][r.idx][k*8 +: 8] = r.dat[k*8 +: 8];
                            end else begin
                                m_dat[g] = mmem[g][r.idx];
                            end
                        end
                    end
                    if (stb[g] && !m_stall[g]) begin
                        req_t n;
                        int a, b;
                        a = edge_n + 1 + ws_of(g);
                        b = m_last[g] + ws_of(g) + 1;
                        n.g = g; n.we = we[g]; n.sel = sel[g]; n.dat = dat_w[g];
                        n.idx = int'((adr[g] >> 2) & 32'hFF);
                        n.ok = ((adr[g] >> 10) == 32'd0);
                        n.resp = (a > b) ? a : b;
                        m_last[g] = n.resp;
                        pend.push_back(n);
                        m_acc[g] = 1;
                    end
                end
                m_stall[g] = (count_of(g) == fd_of(g));
            end
        end
    end

    // Compare process: every cycle, away from the active edge
    initial forever begin
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            if (ack[g] || err[g]) log_q.push_back('{g, edge_n, err[g], dat_r[g]});
            if (stall[g]) stall_seen[g] = 1;
            chk($sformatf("ack%0d", g),   32'(ack[g]),   rst_n ? 32'(m_ack[g])   : 32'd0);
            chk($sformatf("err%0d", g),   32'(err[g]),   rst_n ? 32'(m_err[g])   : 32'd0);
            chk($sformatf("stall%0d", g), 32'(stall[g]), rst_n ? 32'(m_stall[g]) : 32'd0);
            chk($sformatf("dat%0d", g),   dat_r[g],      rst_n ? m_dat[g]        : 32'd0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, compared=%0d", compared);
        $fatal(1, "watchdog expired");
    end

    task automatic idle(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic req(int g, bit w, logic [31:0] a, logic [3:0] s, logic [31:0] d, output int acc);
        int n = 0;
        cyc[g] = 1; stb[g] = 1; we[g] = w; adr[g] = a; sel[g] = s; dat_w[g] = d;
        acc = -1;
        while (acc < 0 && n < 100) begin
            @(posedge clk); #1; n++;
            if (m_acc[g]) acc = edge_n;
        end
        stb[g] = 0;
        if (acc < 0) begin
            compared++; mism++;
            $display("FAIL accept%0d: got=not accepted expected=accepted within 100 cycles", g);
        end
    endtask

    initial begin
        int a1, a2, a3, a4, acc;
        for (int g = 0; g < 3; g++) begin
            cyc[g] = 0; stb[g] = 0; we[g] = 0; adr[g] = '0; sel[g] = '0; dat_w[g] = '0;
        end
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        for (int g = 0; g < 3; g++) chk($sformatf("reset_dat%0d", g), dat_r[g], 32'd0);

        // Fill words 0..15 of every instance so later reads are predictable
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 16; i++) req(g, 1, 32'(i * 4), 4'hF, $urandom, acc);
            idle(8);
            cyc[g] = 0;
        end
        idle(2);

        // W=0: write then read, ack one edge after acceptance
        log_q.delete();
        req(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, a1);
        req(0, 0, 32'h10, 4'hF, 32'h0, a2);
        idle(3);
        chk("t1_lat_wr", 32'(log_e(0)), 32'(a1 + 1));
        chk("t1_lat_rd", 32'(log_e(1)), 32'(a2 + 1));
        chk("t1_rd_data", log_d(1), 32'hDEADBEEF);

        // Byte lanes
        log_q.delete();
        req(0, 1, 32'h20, 4'hF, 32'h11223344, acc);
        req(0, 1, 32'h20, 4'h5, 32'hAABBCCDD, acc);
        req(0, 0, 32'h20, 4'h0, 32'h0, acc);
        idle(3);
        chk("t2_lanes", log_d(2), 32'h11BB33DD);
        cyc[0] = 0;

        // W=3, FIFO of 2: four back-to-back strobes
        idle(1);
        log_q.delete();
        stall_seen[1] = 0;
        req(1, 1, 32'h40, 4'hF, 32'hC0FFEE01, a1);
        req(1, 1, 32'h44, 4'hF, 32'hC0FFEE02, a2);
        req(1, 0, 32'h40, 4'hF, 32'h0, a3);
        req(1, 0, 32'h44, 4'hF, 32'h0, a4);
        idle(20);
        chk("t3_count", 32'(log_q.size()), 32'd4);
        chk("t3_first_lat", 32'(log_e(0)), 32'(a1 + 4));
        for (int i = 0; i < 3; i++) chk($sformatf("t3_gap%0d", i), 32'(log_e(i + 1) - log_e(i)), 32'd4);
        chk("t3_rd0", log_d(2), 32'hC0FFEE01);
        chk("t3_rd1", log_d(3), 32'hC0FFEE02);
        chk("t3_stall_seen", 32'(stall_seen[1]), 32'd1);

        // Out of range read and write
        req(0, 1, 32'h0, 4'hF, 32'h0BADF00D, acc);
        req(0, 0, 32'h10, 4'hF, 32'h0, acc);
        idle(3);
        log_q.delete();
        req(0, 0, 32'h400, 4'hF, 32'h0, acc);
        idle(3);
        chk("t4_err_count", 32'(log_q.size()), 32'd1);
        chk("t4_err", log_er(0), 32'd1);
        chk("t4_dat_held", dat_r[0], 32'hDEADBEEF);
        req(0, 1, 32'h400, 4'hF, 32'hFFFFFFFF, acc);
        req(0, 0, 32'h0, 4'hF, 32'h0, acc);
        idle(3);
        chk("t4_wr_err", log_er(1), 32'd1);
        chk("t4_word0", log_d(2), 32'h0BADF00D);
        cyc[0] = 0;

        // Abort with W=2: A completes, B is discarded
        req(2, 1, 32'h8, 4'hF, 32'h55555555, acc);
        idle(6);
        log_q.delete();
        req(2, 1, 32'h4, 4'hF, 32'hAAAA0001, a1);
        req(2, 1, 32'h8, 4'hF, 32'hBBBB0002, a2);
        idle(3);
        cyc[2] = 0;
        idle(3);
        chk("t5_only_A", 32'(log_q.size()), 32'd1);
        req(2, 0, 32'h4, 4'hF, 32'h0, acc);
        req(2, 0, 32'h8, 4'hF, 32'h0, acc);
        idle(8);
        chk("t5_A", log_d(1), 32'hAAAA0001);
        chk("t5_B_kept", log_d(2), 32'h55555555);
        cyc[2] = 0;

        // Reset in the middle of a wait
        req(1, 0, 32'h40, 4'hF, 32'h0, acc);
        idle(1);
        rst_n = 0;
        #2;
        chk("t6_ack", 32'(ack[1]), 32'd0);
        chk("t6_err", 32'(err[1]), 32'd0);
        chk("t6_stall", 32'(stall[1]), 32'd0);
        chk("t6_dat", dat_r[1], 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        log_q.delete();
        req(1, 1, 32'h48, 4'hF, 32'h12345678, a1);
        idle(8);
        chk("t6_one_resp", 32'(log_q.size()), 32'd1);
        chk("t6_lat", 32'(log_e(0)), 32'(a1 + 4));
        cyc[1] = 0;

        // Randomized traffic with gaps, aborts and out-of-range addresses
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 60; i++) begin
                int r;
                logic [31:0] a;
                r = int'($urandom % 16);
                if (r == 0) begin
                    cyc[g] = 0;
                    idle(1 + int'($urandom % 2));
                end else if (r < 4) begin
                    idle(1);
                end
                a = (($urandom % 16) * 4) | ($urandom % 4);
                if ($urandom % 8 == 0) a = a | (32'd1 << (10 + $urandom % 22));
                req(g, 1'($urandom), a, 4'($urandom), $urandom, acc);
            end
            idle(12);
            cyc[g] = 0;
            idle(2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
